// File: rtl/cmip_sch_pkg.sv
// rtl/cmip_sch_pkg.sv - shared state encoding and helpers for the cmip schedulers
package cmip_sch_pkg;

  // Scheduler FSM encoding
  localparam logic [0:0] ST_UNLOCK = 1'b0;
  localparam logic [0:0] ST_LOCK   = 1'b1;

  // One-hot vector to binary index; an all-zero vector maps to 0
  function automatic logic [31:0] oh_to_idx(input logic [31:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 32'(i);
    end
    return idx;
  endfunction

  // A programmed weight of zero still grants one packet per turn
  function automatic logic [31:0] wgt_nz(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/cmip_rr_pick.sv
// rtl/cmip_rr_pick.sv - combinational masked find-first-one round-robin picker
module cmip_rr_pick #(
  parameter int REQ_WDTH = 8,
  parameter int IDX_WDTH = 3
) (
  input  logic [REQ_WDTH-1:0] i_req,
  input  logic [IDX_WDTH:0]   i_ptr,
  output logic [REQ_WDTH-1:0] o_oh,
  output logic [IDX_WDTH-1:0] o_idx,
  output logic                o_vld
);
  import cmip_sch_pkg::*;

  localparam logic [REQ_WDTH-1:0] L_ONES = '1;
  localparam logic [REQ_WDTH-1:0] L_ONE  = REQ_WDTH'(1);

  logic [REQ_WDTH-1:0] w_masked;
  logic [REQ_WDTH-1:0] w_srch;

  // Requests at or above the pointer win first; a pointer of REQ_WDTH masks everything
  assign w_masked = i_req & (L_ONES << i_ptr);
  assign w_srch   = (|w_masked) ? w_masked : i_req;
  // Lowest set bit isolation
  assign o_oh     = w_srch & (~w_srch + L_ONE);
  assign o_idx    = IDX_WDTH'(oh_to_idx(32'(o_oh)));
  assign o_vld    = |i_req;

endmodule

// File: rtl/cmip_wrr_sch.sv
// rtl/cmip_wrr_sch.sv - packet-aware weighted round-robin scheduler (optional CMIP_WRR_TMO_EN idle timeout)
module cmip_wrr_sch #(
  parameter int REQ_WDTH = 8,
  parameter int IDX_WDTH = 3,
  parameter int WGT_WDTH = 4,
  parameter int FLOP_OUT = 0,
  parameter int TMO_WDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_rdy,
  input  logic [REQ_WDTH-1:0]          i_req,
  input  logic                         i_eop,
  input  logic [REQ_WDTH*WGT_WDTH-1:0] i_wgt,
  output logic                         o_gnt_vld,
  output logic [REQ_WDTH-1:0]          o_gnt,
  output logic [IDX_WDTH-1:0]          o_gnt_idx,
  output logic                         o_lock,
  output logic                         o_tmo
);
  import cmip_sch_pkg::*;

  localparam logic [IDX_WDTH-1:0] L_LAST   = IDX_WDTH'(REQ_WDTH - 1);
  localparam logic [WGT_WDTH-1:0] L_CR_ONE = WGT_WDTH'(1);
  localparam logic [REQ_WDTH-1:0] L_ONE    = REQ_WDTH'(1);

  logic [0:0]          r_state;
  logic [IDX_WDTH:0]   r_ptr;
  logic [IDX_WDTH-1:0] r_cur;
  logic [WGT_WDTH-1:0] r_credit;
  logic                r_bnd;

  logic [REQ_WDTH-1:0] w_pk_oh;
  logic [IDX_WDTH-1:0] w_pk_idx;
  logic                w_pk_vld;
  logic [WGT_WDTH-1:0] w_wgt_arr [REQ_WDTH];
  logic [WGT_WDTH-1:0] w_wgt_eff;
  logic                w_req_cur;
  logic                w_gnt_vld;
  logic [REQ_WDTH-1:0] w_gnt;
  logic [IDX_WDTH-1:0] w_gnt_idx;
  logic                w_rel;
  logic                w_tmo_hit;

  function automatic logic [IDX_WDTH:0] f_next(input logic [IDX_WDTH-1:0] idx);
    return (idx == L_LAST) ? '0 : ((IDX_WDTH+1)'(idx) + (IDX_WDTH+1)'(1));
  endfunction

  cmip_rr_pick #(.REQ_WDTH(REQ_WDTH), .IDX_WDTH(IDX_WDTH)) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_oh  (w_pk_oh),
    .o_idx (w_pk_idx),
    .o_vld (w_pk_vld)
  );

  for (genvar k = 0; k < REQ_WDTH; k++) begin : g_wgt
    assign w_wgt_arr[k] = i_wgt[k*WGT_WDTH +: WGT_WDTH];
  end

  assign w_wgt_eff = WGT_WDTH'(wgt_nz(32'(w_wgt_arr[w_pk_idx])));
  assign w_req_cur = i_req[r_cur];

  // Grant selection: arbitration winner when unlocked, held channel when locked; forced quiet in reset
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_gnt_idx = '0;
    if (i_rst_n) begin
      if (r_state == ST_LOCK) begin
        w_gnt_vld = i_rdy & w_req_cur;
        w_gnt     = L_ONE << r_cur;
        w_gnt_idx = r_cur;
      end else begin
        w_gnt_vld = i_rdy & w_pk_vld;
        w_gnt     = w_pk_oh;
        w_gnt_idx = w_pk_idx;
      end
    end
  end

  // Leave LOCK on credit exhaustion, at an idle packet boundary, or on timeout
  assign w_rel = (w_gnt_vld && i_eop && (r_credit == L_CR_ONE)) ||
                 (r_bnd && !w_req_cur) || w_tmo_hit;

  // Lock/credit/pointer state machine
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_UNLOCK;
      r_ptr    <= '0;
      r_cur    <= '0;
      r_credit <= '0;
      r_bnd    <= 1'b0;
    end else if (r_state == ST_UNLOCK) begin
      if (w_gnt_vld) begin
        if (i_eop && (w_wgt_eff == L_CR_ONE)) begin
          r_ptr <= f_next(w_pk_idx);
        end else begin
          r_state  <= ST_LOCK;
          r_cur    <= w_pk_idx;
          r_credit <= w_wgt_eff - WGT_WDTH'(i_eop);
          r_bnd    <= i_eop;
        end
      end
    end else if (w_rel) begin
      r_state  <= ST_UNLOCK;
      r_ptr    <= f_next(r_cur);
      r_credit <= '0;
      r_bnd    <= 1'b0;
    end else if (w_gnt_vld) begin
      r_bnd <= i_eop;
      if (i_eop) r_credit <= r_credit - L_CR_ONE;
    end
  end

`ifdef CMIP_WRR_TMO_EN
  localparam logic [TMO_WDTH-1:0] L_TMO_LAST = {{(TMO_WDTH-1){1'b1}}, 1'b0};

  logic [TMO_WDTH-1:0] r_tmo_cnt;
  logic                r_tmo;

  // Fires on the cycle the stall counter would reach all-ones
  assign w_tmo_hit = (r_state == ST_LOCK) && !r_bnd && !w_req_cur && (r_tmo_cnt == L_TMO_LAST);

  // Count mid-packet stall cycles of the held channel; pulse o_tmo after a forced release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
      r_tmo     <= 1'b0;
    end else begin
      r_tmo <= w_tmo_hit;
      if ((r_state == ST_UNLOCK) || w_req_cur || r_bnd || w_tmo_hit) r_tmo_cnt <= '0;
      else r_tmo_cnt <= r_tmo_cnt + TMO_WDTH'(1);
    end
  end

  assign o_tmo = r_tmo;
`else
  assign w_tmo_hit = 1'b0;
  assign o_tmo     = 1'b0;
`endif

  assign o_lock = (r_state == ST_LOCK);

  if (FLOP_OUT != 0) begin : g_flop
    logic                r_gnt_vld;
    logic [REQ_WDTH-1:0] r_gnt;
    logic [IDX_WDTH-1:0] r_gnt_idx;

    // Registered grant outputs, one cycle behind the decision
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_gnt_vld <= 1'b0;
        r_gnt     <= '0;
        r_gnt_idx <= '0;
      end else begin
        r_gnt_vld <= w_gnt_vld;
        r_gnt     <= w_gnt;
        r_gnt_idx <= w_gnt_idx;
      end
    end

    assign o_gnt_vld = r_gnt_vld;
    assign o_gnt     = r_gnt;
    assign o_gnt_idx = r_gnt_idx;
  end else begin : g_comb
    assign o_gnt_vld = w_gnt_vld;
    assign o_gnt     = w_gnt;
    assign o_gnt_idx = w_gnt_idx;
  end

endmodule

// File: tb/tb_cmip_wrr_sch.sv
// tb/tb_cmip_wrr_sch.sv - self-checking bench for cmip_wrr_sch
module tb_cmip_wrr_sch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic        eop = 1'b0;
  logic [7:0]  req = 8'h00;
  logic [31:0] wgt = 32'h1111_1111;

  logic       gnt_vld, lock, tmo;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       f_gnt_vld, f_lock, f_tmo;
  logic [7:0] f_gnt;
  logic [2:0] f_gnt_idx;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cmip_wrr_sch #(.REQ_WDTH(8), .IDX_WDTH(3), .WGT_WDTH(4), .FLOP_OUT(0), .TMO_WDTH(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rdy(rdy), .i_req(req), .i_eop(eop), .i_wgt(wgt),
    .o_gnt_vld(gnt_vld), .o_gnt(gnt), .o_gnt_idx(gnt_idx), .o_lock(lock), .o_tmo(tmo)
  );

  cmip_wrr_sch #(.REQ_WDTH(8), .IDX_WDTH(3), .WGT_WDTH(4), .FLOP_OUT(1), .TMO_WDTH(4)) u_dut_f (
    .i_clk(clk), .i_rst_n(rst_n), .i_rdy(rdy), .i_req(req), .i_eop(eop), .i_wgt(wgt),
    .o_gnt_vld(f_gnt_vld), .o_gnt(f_gnt), .o_gnt_idx(f_gnt_idx), .o_lock(f_lock), .o_tmo(f_tmo)
  );

  typedef struct {
    logic [31:0] wgt;
    logic [7:0]  req;
    logic        eop;
    logic        rdy;
    logic        vld;
    logic [7:0]  gnt;
    logic [2:0]  idx;
    logic        lock;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] w, input logic [7:0] r, input logic e, input logic d,
                     input logic v, input logic [7:0] g, input logic [2:0] i, input logic l);
    vec_t t;
    t.wgt = w; t.req = r; t.eop = e; t.rdy = d;
    t.vld = v; t.gnt = g; t.idx = i; t.lock = l;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic [7:0] r, input logic e, input logic d);
    @(negedge clk);
    req = r; eop = e; rdy = d;
    #2;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [7:0] g,
                         input logic [2:0] i, input logic l);
    chk({nm, "_vld"}, 32'(gnt_vld), 32'(v));
    chk({nm, "_gnt"}, 32'(gnt), 32'(g));
    chk({nm, "_idx"}, 32'(gnt_idx), 32'(i));
    chk({nm, "_lock"}, 32'(lock), 32'(l));
  endtask

  initial begin
    logic       pv;
    logic [7:0] pg;
    logic [2:0] pi;

    // Equal weights, everyone requesting, single-beat packets: plain rotation
    for (int n = 0; n < 8; n++) add(32'h1111_1111, 8'hFF, 1'b1, 1'b1, 1'b1, 8'(1 << n), 3'(n), 1'b0);
    // ch0 weight 3, ch1 weight 1: 0,0,0,1,0,0,0,1
    add(32'h1111_1113, 8'h03, 1, 1, 1, 8'h01, 3'd0, 0);
    add(32'h1111_1113, 8'h03, 1, 1, 1, 8'h01, 3'd0, 1);
    add(32'h1111_1113, 8'h03, 1, 1, 1, 8'h01, 3'd0, 1);
    add(32'h1111_1113, 8'h03, 1, 1, 1, 8'h02, 3'd1, 0);
    add(32'h1111_1113, 8'h03, 1, 1, 1, 8'h01, 3'd0, 0);
    add(32'h1111_1113, 8'h03, 1, 1, 1, 8'h01, 3'd0, 1);
    add(32'h1111_1113, 8'h03, 1, 1, 1, 8'h01, 3'd0, 1);
    add(32'h1111_1113, 8'h03, 1, 1, 1, 8'h02, 3'd1, 0);
    // Lock on ch0 mid-packet, then 10 stalled cycles with other requests changing
    add(32'h1111_1113, 8'h03, 0, 1, 1, 8'h01, 3'd0, 0);
    for (int n = 0; n < 10; n++) add(32'h1111_1113, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1);
    // Full credit of 3 packets still available after the stall
    add(32'h1111_1113, 8'h03, 1, 1, 1, 8'h01, 3'd0, 1);
    add(32'h1111_1113, 8'h03, 1, 1, 1, 8'h01, 3'd0, 1);
    add(32'h1111_1113, 8'h03, 1, 1, 1, 8'h01, 3'd0, 1);
    add(32'h1111_1113, 8'h03, 1, 1, 1, 8'h02, 3'd1, 0);
    // ch2 weight 4: one packet then request drops at the boundary -> early release
    add(32'h1111_1413, 8'h04, 1, 1, 1, 8'h04, 3'd2, 0);
    add(32'h1111_1413, 8'h08, 0, 1, 0, 8'h04, 3'd2, 1);
    add(32'h1111_1413, 8'h08, 1, 1, 1, 8'h08, 3'd3, 0);
    add(32'h1111_1413, 8'h00, 1, 1, 0, 8'h00, 3'd0, 0);
    // ch4 weight 0 behaves as weight 1: never locks
    add(32'h1110_1413, 8'h10, 1, 1, 1, 8'h10, 3'd4, 0);
    add(32'h1110_1413, 8'h10, 1, 1, 1, 8'h10, 3'd4, 0);

    // Reset state, with requests present
    req = 8'hFF; rdy = 1'b1; eop = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk_out("rst", 1'b0, 8'h00, 3'd0, 1'b0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    chk("rst_f_vld", 32'(f_gnt_vld), 32'd0);
    chk("rst_f_gnt", 32'(f_gnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    pv = 1'b0; pg = 8'h00; pi = 3'd0;
    for (int n = 0; n < tbl.size(); n++) begin
      @(negedge clk);
      wgt = tbl[n].wgt; req = tbl[n].req; eop = tbl[n].eop; rdy = tbl[n].rdy;
      #2;
      chk_out($sformatf("v%0d", n), tbl[n].vld, tbl[n].gnt, tbl[n].idx, tbl[n].lock);
      chk($sformatf("v%0d_f_vld", n), 32'(f_gnt_vld), 32'(pv));
      chk($sformatf("v%0d_f_gnt", n), 32'(f_gnt), 32'(pg));
      chk($sformatf("v%0d_f_idx", n), 32'(f_gnt_idx), 32'(pi));
      chk($sformatf("v%0d_f_lock", n), 32'(f_lock), 32'(tbl[n].lock));
      pv = tbl[n].vld; pg = tbl[n].gnt; pi = tbl[n].idx;
    end

    // ch2 4-beat packet, request drops for 5 cycles after beat 2
    drive(8'h04, 0, 1); chk_out("drop_b1", 1, 8'h04, 3'd2, 0);
    drive(8'h04, 0, 1); chk_out("drop_b2", 1, 8'h04, 3'd2, 1);
    for (int n = 0; n < 5; n++) begin
      drive(8'h00, 0, 1); chk_out($sformatf("drop_h%0d", n), 0, 8'h04, 3'd2, 1);
    end
    drive(8'h04, 0, 1); chk_out("drop_b3", 1, 8'h04, 3'd2, 1);
    drive(8'h04, 1, 1); chk_out("drop_b4", 1, 8'h04, 3'd2, 1);
    drive(8'h00, 0, 1); chk_out("drop_rel", 0, 8'h04, 3'd2, 1);
    drive(8'hFF, 0, 0); chk_out("drop_ptr3", 0, 8'h08, 3'd3, 0);

    // Reset mid-packet on ch5
    drive(8'h20, 0, 1); chk_out("r5_b1", 1, 8'h20, 3'd5, 0);
    drive(8'h21, 0, 1); chk_out("r5_b2", 1, 8'h20, 3'd5, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_out("r5_rst", 0, 8'h00, 3'd0, 0);
    chk("r5_rst_tmo", 32'(tmo), 32'd0);
    chk("r5_rst_f_vld", 32'(f_gnt_vld), 32'd0);
    chk("r5_rst_f_gnt", 32'(f_gnt), 32'd0);
    chk("r5_rst_f_lock", 32'(f_lock), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(8'h21, 1, 1); chk_out("r5_after", 1, 8'h01, 3'd0, 0);
    drive(8'h00, 0, 0); chk_out("r5_bnd", 0, 8'h01, 3'd0, 1);

    // Mid-packet stall on ch1 for 15 cycles
    drive(8'h02, 0, 1); chk_out("tmo_b1", 1, 8'h02, 3'd1, 0);
    for (int n = 0; n < 15; n++) begin
      drive(8'h00, 0, 1);
      chk($sformatf("tmo_hold%0d_lock", n), 32'(lock), 32'd1);
      chk($sformatf("tmo_hold%0d_tmo", n), 32'(tmo), 32'd0);
    end
`ifdef CMIP_WRR_TMO_EN
    drive(8'h00, 0, 1);
    chk("tmo_pulse", 32'(tmo), 32'd1);
    chk("tmo_unlock", 32'(lock), 32'd0);
    drive(8'hFF, 0, 0);
    chk("tmo_pulse_end", 32'(tmo), 32'd0);
    chk_out("tmo_ptr2", 0, 8'h04, 3'd2, 0);
`else
    for (int n = 0; n < 5; n++) drive(8'h00, 0, 1);
    chk("hold_lock", 32'(lock), 32'd1);
    chk("hold_tmo", 32'(tmo), 32'd0);
    drive(8'h02, 1, 1); chk_out("hold_resume", 1, 8'h02, 3'd1, 1);
    drive(8'hFF, 0, 0); chk_out("hold_ptr2", 0, 8'h04, 3'd2, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
